rv32i_pipeline_core: RTL and testbench

- Self-contained RV32I (user integer subset + machine CSRs/trap) 5-stage in-order pipelined processor with unified internal instruction/data memory.
- Top level of the CPU. The bench preloads memory, runs the core and checks architectural state.
- Used to run rv32ui-p riscv-tests. Pass condition: fetch PC reaches 0x44 with x3 == 1.

---
 rtl/rv32i_pipeline_core.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_rv32i_pipeline_core.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_pipeline_core.sv
// RV32I five-stage in-order pipeline (IF/ID/EX/MEM/WB) with machine CSRs, ECALL/MRET
// and a unified byte-addressed memory with separate fetch and load read ports.

module rv32i_mem #(
  parameter int unsigned MEM_BYTES = 65536,
  localparam int unsigned AW = $clog2(MEM_BYTES)
) (
  input  logic          clk,
  input  logic [AW-1:0] iaddr,
  output logic [31:0]   idata,
  input  logic [AW-1:0] daddr,
  output logic [31:0]   drdata,
  input  logic          we,
  input  logic [1:0]    wsize,
  input  logic [31:0]   wdata
);
  logic [7:0] m [MEM_BYTES];
  logic [3:0] wmask;

  // Little-endian byte assembly; address arithmetic wraps at the memory size.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      idata[8*k +: 8]  = m[iaddr + AW'(k)];
      drdata[8*k +: 8] = m[daddr + AW'(k)];
    end
    case (wsize)
      2'b00:   wmask = 4'b0001;
      2'b01:   wmask = 4'b0011;
      default: wmask = 4'b1111;
    endcase
  end

  always_ff @(posedge clk) begin
    if (we) begin
      for (int k = 0; k < 4; k++) begin
        if (wmask[k]) m[daddr + AW'(k)] <= wdata[8*k +: 8];
      end
    end
  end
endmodule

module rv32i_pipeline_core #(
  parameter int unsigned MEM_BYTES = 65536,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input logic clk,
  input logic rst
);
  localparam int unsigned AW = $clog2(MEM_BYTES);
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] ECALL = 32'h0000_0073;
  localparam logic [31:0] MRET  = 32'h3020_0073;
  localparam logic [6:0] OP_LUI = 7'h37, OP_AUIPC = 7'h17, OP_JAL = 7'h6f, OP_JALR = 7'h67,
                         OP_BR  = 7'h63, OP_LD    = 7'h03, OP_ST  = 7'h23, OP_IMM  = 7'h13,
                         OP_OP  = 7'h33, OP_SYS   = 7'h73;

  logic [31:0] rs  [32];
  logic [31:0] csr [4096];
  logic [31:0] if_pc, if_instr;

  logic        id_valid;
  logic [31:0] id_pc, id_instr, id_v1, id_v2;
  logic [4:0]  id_rs1, id_rs2;

  logic        ex_valid;
  logic [31:0] ex_pc, ex_instr, ex_rv1, ex_rv2;
  logic [6:0]  ex_op;
  logic [2:0]  ex_f3;
  logic [4:0]  ex_rd, ex_rs1, ex_rs2;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, a, b, op2, alu;
  logic [31:0] ex_result, target, csr_old, csr_src, csr_wval;
  logic [11:0] csr_addr;
  logic        take, ex_we, ex_load, ex_store, redirect, csr_we, ecall, is_csr, stall;

  logic        mem_we, mem_load, mem_store;
  logic [4:0]  mem_rd;
  logic [2:0]  mem_f3;
  logic [31:0] mem_result, mem_sdata, mem_rdata, ld_data, mem_fwd;

  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  rv32i_mem #(.MEM_BYTES(MEM_BYTES)) memory (
    .clk   (clk),
    .iaddr (if_pc[AW-1:0]),
    .idata (if_instr),
    .daddr (mem_result[AW-1:0]),
    .drdata(mem_rdata),
    .we    (mem_store),
    .wsize (mem_f3[1:0]),
    .wdata (mem_sdata)
  );

  // ID register read; the value WB writes this cycle is returned directly.
  assign id_rs1 = id_instr[19:15];
  assign id_rs2 = id_instr[24:20];
  always_comb begin
    id_v1 = (wb_we && wb_rd == id_rs1) ? wb_data : rs[id_rs1];
    id_v2 = (wb_we && wb_rd == id_rs2) ? wb_data : rs[id_rs2];
  end

  assign ex_op    = ex_instr[6:0];
  assign ex_f3    = ex_instr[14:12];
  assign ex_rd    = ex_instr[11:7];
  assign ex_rs1   = ex_instr[19:15];
  assign ex_rs2   = ex_instr[24:20];
  assign csr_addr = ex_instr[31:20];
  assign imm_i = {{20{ex_instr[31]}}, ex_instr[31:20]};
  assign imm_s = {{20{ex_instr[31]}}, ex_instr[31:25], ex_instr[11:7]};
  assign imm_b = {{19{ex_instr[31]}}, ex_instr[31], ex_instr[7], ex_instr[30:25], ex_instr[11:8], 1'b0};
  assign imm_u = {ex_instr[31:12], 12'b0};
  assign imm_j = {{11{ex_instr[31]}}, ex_instr[31], ex_instr[19:12], ex_instr[20], ex_instr[30:21], 1'b0};

  // Operand forwarding: EX/MEM beats MEM/WB beats the value read in ID.
  assign mem_fwd = mem_load ? ld_data : mem_result;
  always_comb begin
    a = (mem_we && mem_rd == ex_rs1) ? mem_fwd : (wb_we && wb_rd == ex_rs1) ? wb_data : ex_rv1;
    b = (mem_we && mem_rd == ex_rs2) ? mem_fwd : (wb_we && wb_rd == ex_rs2) ? wb_data : ex_rv2;
  end

  always_comb begin
    op2 = (ex_op == OP_OP) ? b : imm_i;
    case (ex_f3)
      3'b000:  alu = (ex_op == OP_OP && ex_instr[30]) ? a - op2 : a + op2;
      3'b001:  alu = a << op2[4:0];
      3'b010:  alu = {31'b0, $signed(a) < $signed(op2)};
      3'b011:  alu = {31'b0, a < op2};
      3'b100:  alu = a ^ op2;
      3'b101:  alu = ex_instr[30] ? 32'($signed(a) >>> op2[4:0]) : a >> op2[4:0];
      3'b110:  alu = a | op2;
      default: alu = a & op2;
    endcase
    case (ex_f3)
      3'b000:  take = (a == b);
      3'b001:  take = (a != b);
      3'b100:  take = $signed(a) < $signed(b);
      3'b101:  take = $signed(a) >= $signed(b);
      3'b110:  take = a < b;
      3'b111:  take = a >= b;
      default: take = 1'b0;
    endcase
  end

  // EX: result, control-flow redirect and CSR read/modify/write.
  always_comb begin
    ex_result = '0;
    ex_we     = 1'b0;
    ex_load   = 1'b0;
    ex_store  = 1'b0;
    redirect  = 1'b0;
    target    = '0;
    csr_we    = 1'b0;
    ecall     = 1'b0;
    csr_old   = csr[csr_addr];
    csr_src   = ex_f3[2] ? {27'b0, ex_rs1} : a;
    is_csr    = (ex_op == OP_SYS) && (ex_f3[1:0] != 2'b00);
    case (ex_f3[1:0])
      2'b01:   csr_wval = csr_src;
      2'b10:   csr_wval = csr_old | csr_src;
      default: csr_wval = csr_old & ~csr_src;
    endcase
    case (ex_op)
      OP_LUI:   begin ex_result = imm_u;         ex_we = 1'b1; end
      OP_AUIPC: begin ex_result = ex_pc + imm_u; ex_we = 1'b1; end
      OP_JAL:   begin ex_result = ex_pc + 32'd4; ex_we = 1'b1; redirect = 1'b1; target = ex_pc + imm_j; end
      OP_JALR:  begin ex_result = ex_pc + 32'd4; ex_we = 1'b1; redirect = 1'b1; target = (a + imm_i) & ~32'd1; end
      OP_BR:    begin redirect = take; target = ex_pc + imm_b; end
      OP_LD:    begin ex_result = a + imm_i; ex_we = 1'b1; ex_load = 1'b1; end
      OP_ST:    begin ex_result = a + imm_s; ex_store = 1'b1; end
      OP_IMM, OP_OP: begin ex_result = alu; ex_we = 1'b1; end
      OP_SYS: begin
        if (is_csr) begin
          ex_result = csr_old;
          ex_we     = 1'b1;
          csr_we    = (ex_f3[1:0] == 2'b01) || (ex_rs1 != 5'd0);
        end else if (ex_instr == ECALL) begin
          ecall    = 1'b1;
          redirect = 1'b1;
          target   = csr[12'h305];
        end else if (ex_instr == MRET) begin
          redirect = 1'b1;
          target   = csr[12'h341];
        end
      end
      default: ;
    endcase
    ex_we    = ex_we && ex_valid && (ex_rd != 5'd0);
    ex_load  = ex_load && ex_valid;
    ex_store = ex_store && ex_valid;
    redirect = redirect && ex_valid;
    csr_we   = csr_we && ex_valid;
    ecall    = ecall && ex_valid;
  end

  assign stall = ex_valid && (ex_op == OP_LD) && (ex_rd != 5'd0) && id_valid &&
                 (ex_rd == id_rs1 || ex_rd == id_rs2);

  always_comb begin
    case (mem_f3)
      3'b000:  ld_data = {{24{mem_rdata[7]}}, mem_rdata[7:0]};
      3'b001:  ld_data = {{16{mem_rdata[15]}}, mem_rdata[15:0]};
      3'b100:  ld_data = {24'b0, mem_rdata[7:0]};
      3'b101:  ld_data = {16'b0, mem_rdata[15:0]};
      default: ld_data = mem_rdata;
    endcase
  end

  // Pipeline registers; a redirect wins over a load-use stall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_pc      <= RESET_PC;
      id_valid   <= 1'b0;
      id_pc      <= '0;
      id_instr   <= NOP;
      ex_valid   <= 1'b0;
      ex_pc      <= '0;
      ex_instr   <= NOP;
      ex_rv1     <= '0;
      ex_rv2     <= '0;
      mem_we     <= 1'b0;
      mem_load   <= 1'b0;
      mem_store  <= 1'b0;
      mem_rd     <= '0;
      mem_f3     <= '0;
      mem_result <= '0;
      mem_sdata  <= '0;
      wb_we      <= 1'b0;
      wb_rd      <= '0;
      wb_data    <= '0;
    end else begin
      if (redirect) begin
        if_pc    <= target;
        id_valid <= 1'b0;
        id_instr <= NOP;
        ex_valid <= 1'b0;
        ex_instr <= NOP;
      end else if (stall) begin
        ex_valid <= 1'b0;
        ex_instr <= NOP;
      end else begin
        if_pc    <= if_pc + 32'd4;
        id_valid <= 1'b1;
        id_pc    <= if_pc;
        id_instr <= if_instr;
        ex_valid <= id_valid;
        ex_pc    <= id_pc;
        ex_instr <= id_instr;
        ex_rv1   <= id_v1;
        ex_rv2   <= id_v2;
      end
      mem_we     <= ex_we;
      mem_load   <= ex_load;
      mem_store  <= ex_store;
      mem_rd     <= ex_rd;
      mem_f3     <= ex_f3;
      mem_result <= ex_result;
      mem_sdata  <= b;
      wb_we      <= mem_we;
      wb_rd      <= mem_rd;
      wb_data    <= mem_fwd;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) rs[i] <= '0;
    end else if (wb_we) begin
      rs[wb_rd] <= wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4096; i++) csr[i] <= '0;
    end else begin
      if (csr_we) csr[csr_addr] <= csr_wval;
      if (ecall) begin
        csr[12'h341] <= ex_pc;
        csr[12'h342] <= 32'd11;
      end
    end
  end
endmodule

// File: tb/tb_rv32i_pipeline_core.sv
// Directed programs for rv32i_pipeline_core; architectural results are queued as
// expectations when each program is loaded and compared once the program settles.

module tb_rv32i_pipeline_core;
  logic clk;
  logic rst;

  rv32i_pipeline_core dut (.clk(clk), .rst(rst));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          kind;   // 0 register, 1 csr, 2 memory byte
    logic [15:0] idx;
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] wp;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] f_i(input logic [31:0] imm, input logic [4:0] rs1,
                                      input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm[11:0], rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] f_r(input logic [6:0] f7, input logic [4:0] rs2,
                                      input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction
  function automatic logic [31:0] f_s(input logic [31:0] imm, input logic [4:0] rs2,
                                      input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] f_b(input logic [31:0] imm, input logic [4:0] rs2,
                                      input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] f_u(input logic [19:0] imm, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rd, op};
  endfunction
  function automatic logic [31:0] f_j(input logic [31:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
  endfunction
  function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [31:0] imm);
    return f_i(imm, rs1, 3'd0, rd, 7'h13);
  endfunction

  function automatic logic [31:0] regs_or();
    logic [31:0] acc = '0;
    for (int i = 1; i < 32; i++) acc |= dut.rs[5'(i)];
    return acc;
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 65536; i++) dut.memory.m[16'(i)] = 8'h00;
    wp = '0;
  endtask

  task automatic emit(input logic [31:0] w);
    logic [15:0] a = wp[15:0];
    for (int k = 0; k < 4; k++) dut.memory.m[a + 16'(k)] = w[8*k +: 8];
    wp = wp + 32'd4;
  endtask

  task automatic expect_v(input string tag, input int kind, input logic [15:0] idx, input logic [31:0] val);
    exp_t e;
    e.tag = tag; e.kind = kind; e.idx = idx; e.val = val;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t        e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.kind)
        0:       obs = dut.rs[e.idx[4:0]];
        1:       obs = dut.csr[e.idx[11:0]];
        default: obs = {24'b0, dut.memory.m[e.idx]};
      endcase
      check(e.tag, obs, e.val);
    end
  endtask

  task automatic wait_pc(input logic [31:0] pc, input int budget, input string tag);
    logic found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (dut.if_pc == pc) begin
        found = 1'b1;
        break;
      end
    end
    check(tag, {31'b0, found}, 32'd1);
  endtask

  task automatic step_pc(input string tag, input logic [31:0] pc);
    @(posedge clk); #1;
    check(tag, dut.if_pc, pc);
  endtask

  task automatic restart();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic settle();
    repeat (8) @(posedge clk);
    #1;
    drain();
  endtask

  initial begin
    rst = 1'b0;

    // Reset, forwarding and ALU patterns.
    clear_mem();
    emit(addi(1, 0, 5));
    emit(addi(2, 1, 3));
    emit(f_r(7'h00, 1, 2, 3'd0, 3));
    emit(f_r(7'h20, 2, 1, 3'd0, 7));
    emit(f_r(7'h00, 1, 7, 3'd2, 8));
    emit(f_r(7'h00, 1, 7, 3'd3, 9));
    emit(f_i(32'h401, 7, 3'd5, 10, 7'h13));
    emit(f_i(32'd28, 7, 3'd5, 11, 7'h13));
    emit(f_i(32'd31, 1, 3'd1, 12, 7'h13));
    emit(f_u(20'h12345, 13, 7'h37));
    emit(f_u(20'h00001, 14, 7'h17));
    emit(f_j(32'd0, 0));
    expect_v("fwd_x2", 0, 2, 32'd5 + 32'd3);
    expect_v("fwd_x3", 0, 3, 32'd8 + 32'd5);
    expect_v("sub_x7", 0, 7, 32'd5 - 32'd8);
    expect_v("slt_x8", 0, 8, 32'd1);
    expect_v("sltu_x9", 0, 9, 32'd0);
    expect_v("srai_x10", 0, 10, 32'hffff_fffe);
    expect_v("srli_x11", 0, 11, 32'h0000_000f);
    expect_v("slli_x12", 0, 12, 32'h8000_0000);
    expect_v("lui_x13", 0, 13, 32'h1234_5000);
    expect_v("auipc_x14", 0, 14, 32'h0000_1028);
    repeat (2) @(posedge clk);
    #1;
    check("rst_pc", dut.if_pc, 32'h0);
    check("rst_regs", regs_or(), 32'h0);
    restart();
    step_pc("pc_seq_4", 32'h4);
    step_pc("pc_seq_8", 32'h8);
    wait_pc(32'h2c, 200, "a_reach_end");
    settle();

    // Store/load, load-use stall, byte/half/misaligned accesses.
    rst = 1'b0;
    clear_mem();
    emit(f_u(20'h80000, 1, 7'h37));
    emit(addi(1, 1, 32'hffff_ffff));
    emit(f_s(32'h100, 1, 0, 3'd2));
    emit(f_i(32'h100, 0, 3'd2, 4, 7'h03));
    emit(addi(5, 4, 1));
    emit(addi(2, 0, 32'h80));
    emit(f_s(32'h104, 2, 0, 3'd0));
    emit(f_i(32'h104, 0, 3'd0, 15, 7'h03));
    emit(f_i(32'h104, 0, 3'd4, 16, 7'h03));
    emit(f_i(32'h102, 0, 3'd1, 17, 7'h03));
    emit(f_s(32'h106, 2, 0, 3'd1));
    emit(f_i(32'h103, 0, 3'd2, 18, 7'h03));
    emit(f_j(32'd0, 0));
    expect_v("lw_x4", 0, 4, 32'h7fff_ffff);
    expect_v("loaduse_x5", 0, 5, 32'h7fff_ffff + 32'd1);
    expect_v("lb_x15", 0, 15, 32'hffff_ff80);
    expect_v("lbu_x16", 0, 16, 32'h0000_0080);
    expect_v("lh_x17", 0, 17, 32'h0000_7fff);
    expect_v("lw_misal_x18", 0, 18, 32'h8000_807f);
    expect_v("sb_mem104", 2, 16'h0104, 32'h80);
    expect_v("sh_mem107", 2, 16'h0107, 32'h00);
    restart();
    wait_pc(32'h0c, 50, "b_reach_lw");
    step_pc("lu_pc_10", 32'h10);
    step_pc("lu_pc_14", 32'h14);
    step_pc("lu_stall_14", 32'h14);
    step_pc("lu_pc_18", 32'h18);
    wait_pc(32'h30, 200, "b_reach_end");
    settle();

    // Jumps and branches: flushes, not-taken fall-through, signed vs unsigned.
    rst = 1'b0;
    clear_mem();
    emit(addi(1, 0, 1));
    emit(f_j(32'h3c, 21));
    wp = 32'h40;
    emit(f_b(32'd12, 0, 0, 3'd0));
    emit(addi(6, 0, 7));
    emit(addi(6, 0, 9));
    emit(addi(19, 0, 32'h55));
    emit(f_b(32'd8, 1, 1, 3'd1));
    emit(addi(20, 0, 32'h66));
    emit(f_b(32'd8, 0, 1, 3'd1));
    emit(addi(20, 0, 32'h77));
    emit(addi(22, 0, 32'hffff_fffe));
    emit(f_b(32'd8, 22, 1, 3'd6));
    emit(addi(23, 0, 1));
    emit(f_b(32'd8, 22, 1, 3'd4));
    emit(addi(24, 0, 3));
    emit(f_j(32'd0, 0));
    expect_v("br_flush_x6", 0, 6, 32'd0);
    expect_v("br_target_x19", 0, 19, 32'h55);
    expect_v("bne_x20", 0, 20, 32'h66);
    expect_v("jal_link_x21", 0, 21, 32'h8);
    expect_v("bltu_x23", 0, 23, 32'd0);
    expect_v("blt_x24", 0, 24, 32'd3);
    restart();
    step_pc("c_pc_4", 32'h4);
    step_pc("jal_pc_8", 32'h8);
    step_pc("jal_pc_c", 32'hc);
    step_pc("jal_pc_40", 32'h40);
    step_pc("beq_pc_44", 32'h44);
    step_pc("beq_pc_48", 32'h48);
    step_pc("beq_pc_4c", 32'h4c);
    step_pc("beq_pc_50", 32'h50);
    wait_pc(32'h74, 200, "c_reach_end");
    settle();

    // CSR access, ECALL into mtvec and MRET back to mepc.
    rst = 1'b0;
    clear_mem();
    emit(addi(1, 0, 32'h100));
    emit(f_i(32'h305, 1, 3'd1, 2, 7'h73));
    emit(f_i(32'h305, 0, 3'd2, 3, 7'h73));
    emit(addi(4, 0, 5));
    emit(f_i(32'h340, 5, 3'd5, 0, 7'h73));
    emit(f_i(32'h340, 2, 3'd6, 5, 7'h73));
    emit(f_i(32'h340, 4, 3'd3, 6, 7'h73));
    emit(addi(7, 0, 1));
    emit(32'h0000_0073);
    emit(addi(8, 0, 32'h33));
    wp = 32'h100;
    emit(addi(10, 10, 1));
    emit(addi(11, 0, 2));
    emit(f_b(32'd12, 11, 10, 3'd0));
    emit(32'h3020_0073);
    emit(addi(0, 0, 0));
    emit(f_i(32'h342, 0, 3'd2, 12, 7'h73));
    emit(f_i(32'h341, 0, 3'd2, 13, 7'h73));
    emit(f_j(32'd0, 0));
    expect_v("csrrw_old_x2", 0, 2, 32'd0);
    expect_v("csrrs_read_x3", 0, 3, 32'h100);
    expect_v("csrrsi_old_x5", 0, 5, 32'd5);
    expect_v("csrrc_old_x6", 0, 6, 32'd5 | 32'd2);
    expect_v("ecall_flush_x8", 0, 8, 32'd0);
    expect_v("handler_x10", 0, 10, 32'd2);
    expect_v("mcause_x12", 0, 12, 32'd11);
    expect_v("mepc_x13", 0, 13, 32'h20);
    expect_v("mtvec", 1, 16'h0305, 32'h100);
    expect_v("mscratch", 1, 16'h0340, 32'd7 & ~32'd5);
    expect_v("mepc", 1, 16'h0341, 32'h20);
    expect_v("mcause", 1, 16'h0342, 32'd11);
    restart();
    wait_pc(32'h20, 50, "d_reach_ecall");
    step_pc("ecall_pc_24", 32'h24);
    step_pc("ecall_pc_28", 32'h28);
    step_pc("ecall_pc_mtvec", 32'h100);
    wait_pc(32'h10c, 20, "d_reach_mret");
    step_pc("mret_pc_110", 32'h110);
    step_pc("mret_pc_114", 32'h114);
    step_pc("mret_pc_mepc", 32'h20);
    wait_pc(32'h11c, 100, "d_reach_end");
    settle();

    // Asynchronous reset in the middle of a running program.
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("midrst_pc", dut.if_pc, 32'h0);
    check("midrst_regs", regs_or(), 32'h0);
    check("midrst_mtvec", dut.csr[12'h305], 32'h0);
    check("midrst_mepc", dut.csr[12'h341], 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
